// File: rtl/stim_player_pkg.sv
// Shared types and opcode field layout for the stimulus player.
package stim_player_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int OPC_W     = 6;
  localparam int OBS_BIT   = 5;
  localparam int K_HI      = 4;
  localparam int K_LO      = 1;
  localparam int START_BIT = 0;
  localparam int LOSS_W    = 8;
endpackage

// File: rtl/stim_player_ram.sv
// Opcode store: DEPTH x OPC_W, synchronous write, asynchronous read, no reset.
module stim_player_ram
  import stim_player_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [OPC_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [OPC_W-1:0]  rdata
);
  logic [OPC_W-1:0] mem [DEPTH];

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/stim_player.sv
// Loads a short opcode program, then replays one opcode per cycle onto the game inputs.
// Optional loss counter built when STIM_PLAYER_LOSS_CNT_EN is defined.
module stim_player
  import stim_player_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [5:0]        load_data,
  output logic              load_ready,
  input  logic              run,
  input  logic              pause,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              obs,
  output logic [3:0]        k,
  output logic              start,
  input  logic              nloss_in,
  output logic [7:0]        loss_count
);
  state_t            state;
  logic [ADDR_W:0]   count, count_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [OPC_W-1:0]  rdata;
  logic              wr, go, last;

  assign load_ready = (state == ST_IDLE) && (count < (ADDR_W+1)'(DEPTH));
  assign wr         = load_valid && load_ready && !clear;
  assign count_nxt  = count + (ADDR_W+1)'(wr);
  // a write in the run cycle is part of the program being started
  assign go         = (state == ST_IDLE) && !clear && run && (count_nxt != '0);
  assign last       = ({1'b0, pc} == count - (ADDR_W+1)'(1));

  stim_player_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (wr),
    .waddr (wptr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      wptr  <= '0;
      pc    <= '0;
      obs   <= 1'b0;
      k     <= '0;
      start <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            count <= '0;
            wptr  <= '0;
          end else if (wr) begin
            count <= count_nxt;
            wptr  <= wptr + ADDR_W'(1);
          end
          if (go) begin
            state <= ST_PLAY;
            busy  <= 1'b1;
            pc    <= '0;
          end
        end
        ST_PLAY: begin
          if (!pause) begin
            obs   <= rdata[OBS_BIT];
            k     <= rdata[K_HI:K_LO];
            start <= rdata[START_BIT];
            pc    <= pc + ADDR_W'(1);
            if (last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          pc    <= '0;
          obs   <= 1'b0;
          k     <= '0;
          start <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STIM_PLAYER_LOSS_CNT_EN
  // counts paused PLAY cycles too; cleared only by reset or a new run
  always_ff @(posedge clock) begin
    if (reset)
      loss_count <= '0;
    else if (go)
      loss_count <= '0;
    else if (state == ST_PLAY && nloss_in && loss_count != {LOSS_W{1'b1}})
      loss_count <= loss_count + 8'd1;
  end
`else
  logic unused_nloss;
  assign unused_nloss = nloss_in;
  assign loss_count   = '0;
`endif
endmodule

// File: tb/tb_stim_player.sv
// Randomized scoreboard bench for stim_player: expected playback frames are queued at run time
// and popped by a negedge monitor whenever the player is busy.
module tb_stim_player;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock = 1'b0, reset;
  logic          load_valid, run, pause, clear, nloss_in;
  logic [5:0]    load_data;
  logic          load_ready, busy, done, obs, start;
  logic [3:0]    k;
  logic [AW-1:0] pc;
  logic [7:0]    loss_count;

  stim_player #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .run(run), .pause(pause), .clear(clear), .busy(busy),
    .done(done), .pc(pc), .obs(obs), .k(k), .start(start), .nloss_in(nloss_in),
    .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [5:0]    opc;
    logic [AW-1:0] pc;
    logic [7:0]    loss;
  } frame_t;

  frame_t     exp_q[$];
  bit         mon_en = 1'b0;
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [5:0] prog [DEPTH];
  int         cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] loss_e(input int l);
`ifdef STIM_PLAYER_LOSS_CNT_EN
    return 8'(l);
`else
    return 8'(0 * l);
`endif
  endfunction

  always @(negedge clock) begin : mon
    frame_t a, e;
    if (mon_en && busy === 1'b1) begin
      a = {busy, done, obs, k, start, pc, loss_count};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL frame_unexpected: actual %0h required none", a);
      end else begin
        e = exp_q.pop_front();
        chk("frame", a, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_data = '0; run = 0; pause = 0; clear = 0; nloss_in = 0;
  endtask

  task automatic chk_idle(input string nm, input int l);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_outs"}, {done, obs, k, start, pc}, '0);
    chk({nm, "_loss"}, loss_count, loss_e(l));
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
    cnt = 0;
    chk("clear_ready", load_ready, 1);
  endtask

  task automatic load(input logic [5:0] op);
    chk("load_ready", load_ready, cnt < DEPTH);
    load_valid = 1; load_data = op;
    tick();
    load_valid = 0;
    if (cnt < DEPTH) begin
      prog[cnt] = op;
      cnt++;
    end
  endtask

  // pmode: 0 random pauses/noise, 1 pause cycles 2-3, 2 pause 300 cycles with nloss, 3 no pause
  task automatic play(input int pmode, input bit with_load, input logic [5:0] lop);
    bit         pz[$], nl[$];
    logic [5:0] outs;
    int         pc_m, emitted, loss, c, n;
    bit         p, l;
    load_valid = with_load; load_data = lop;
    if (with_load && cnt < DEPTH) begin
      prog[cnt] = lop;
      cnt++;
    end
    n = cnt; outs = '0; pc_m = 0; emitted = 0; loss = 0; c = 0;
    while (emitted < n) begin
      case (pmode)
        0:       p = ($urandom_range(3) == 0);
        1:       p = (c == 2 || c == 3);
        2:       p = (c < 300);
        default: p = 0;
      endcase
      l = (pmode == 2) ? 1'b1 : 1'($urandom_range(1));
      exp_q.push_back('{1'b1, 1'b0, outs, pc_m[AW-1:0], loss_e(loss)});
      pz.push_back(p); nl.push_back(l);
      if (l && loss < 255) loss++;
      if (!p) begin
        outs = prog[emitted];
        emitted++;
        pc_m = emitted % DEPTH;
      end
      c++;
    end
    exp_q.push_back('{1'b1, 1'b1, outs, pc_m[AW-1:0], loss_e(loss)});
    if (pmode == 1) chk("pause_len", c, n + 2);
    run = 1; tick();
    run = 0; load_valid = 0;
    for (int i = 0; i < c; i++) begin
      pause = pz[i]; nloss_in = nl[i];
      if (pmode == 0) begin
        run = 1'($urandom_range(1)); clear = ($urandom_range(3) == 0);
        load_valid = 1'($urandom_range(1)); load_data = 6'($urandom);
      end
      tick();
    end
    pause = 1'($urandom_range(1)); nloss_in = 1;
    tick();
    idle_inputs();
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    chk_idle("after_run", loss);
    nloss_in = 1; tick(); nloss_in = 0;
    chk("loss_hold", loss_count, loss_e(loss));
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk_idle("reset", 0);
    chk("reset_ready", load_ready, 1);
    reset = 0;
    mon_en = 1;

    run = 1; tick(); run = 0;
    chk("run_empty", busy, 0);

    load(6'b100011); load(6'b000100); load(6'b011111);
    play(3, 0, '0);
    play(1, 0, '0);

    do_clear();
    for (int i = 0; i < DEPTH; i++) load(6'($urandom));
    load(6'($urandom));
    chk("full_ready", load_ready, 0);
    play(0, 0, '0);
    play(2, 0, '0);

    repeat (6) begin
      if ($urandom_range(1)) begin
        do_clear();
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++) load(6'($urandom));
      end
      play(0, 1'($urandom_range(1)), 6'($urandom));
    end

    // reset in the middle of playback
    do_clear();
    for (int i = 0; i < 5; i++) load(6'($urandom));
    mon_en = 0;
    run = 1; tick(); run = 0;
    tick(); tick();
    chk("mid_pc", pc, 2);
    reset = 1; tick(); reset = 0;
    cnt = 0;
    chk_idle("mid_reset", 0);
    run = 1; tick(); run = 0;
    chk("rst_run_ignored", busy, 0);
    tick();
    chk("rst_no_done", done, 0);
    mon_en = 1;

    // clear beats run and load in the same cycle
    load(6'($urandom)); load(6'($urandom));
    clear = 1; run = 1; load_valid = 1; load_data = 6'($urandom);
    tick();
    idle_inputs();
    cnt = 0;
    chk("clr_busy", busy, 0);
    chk("clr_ready", load_ready, 1);
    run = 1; tick(); run = 0;
    chk("clr_run_ignored", busy, 0);
    load(6'($urandom));
    play(3, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
- REQ-001: Parameter DEPTH, default 8, number of opcode slots (power of two, 2..64).
- REQ-002: Parameter ADDR_W, default $clog2(DEPTH), pointer width.
- REQ-003: clock  input  1  single clock; all state changes on rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: load_valid  input  1  opcode write request.
- REQ-006: load_data  input  6  opcode: [5]=obs, [4:1]=k, [0]=start.
- REQ-007: load_ready  output  1  write accepted when load_valid&&load_ready.
- REQ-008: run  input  1  start-playback pulse.
- REQ-009: pause  input  1  freeze playback while high.
- REQ-010: clear  input  1  discard loaded program.
- REQ-011: busy  output  1  high in PLAY or DONE.
- REQ-012: done  output  1  one-cycle end-of-program pulse.
- REQ-013: pc  output  ADDR_W  current playback pointer.
- REQ-014: obs, k[3:0], start  outputs  1/4/1  registered drive to the b12 game inputs __obs, k, start.
- REQ-015: nloss_in  input  1  b12 nloss observed during playback.
- REQ-016: loss_count  output  8  count of PLAY cycles with nloss_in=1.

Function
- REQ-017: States IDLE, PLAY, DONE. Encoding lives in the shared package.
- REQ-018: load_ready = (state==IDLE) && (count<DEPTH). An accepted write stores load_data at wptr, then increments wptr and count.
- REQ-019: IDLE->PLAY on run=1 when count>0 after this cycle's write. A simultaneous write is included in the program. pc <= 0, loss_count <= 0.
- REQ-020: run with count==0 is ignored. run outside IDLE is ignored.
- REQ-021: In PLAY with pause=0, each edge: {obs,k,start} <= ram[pc] fields; pc <= pc+1.
- REQ-022: Opcode i appears on the outputs after edge i+1 counted from the run edge. One opcode per cycle, no bubbles.
- REQ-023: pause=1 in PLAY holds pc, outputs and state. It does not stop loss counting.
- REQ-024: The edge that emits opcode count-1 moves PLAY->DONE. Outputs hold that opcode during DONE.
- REQ-025: DONE lasts exactly one cycle with done=1, then returns to IDLE. In IDLE, obs/k/start = 0 and pc = 0.
- REQ-026: clear in IDLE sets count and wptr to 0. clear has priority over a simultaneous run and load. clear outside IDLE is ignored.
- REQ-027: The program persists across runs. A new run replays from pc=0.
- REQ-028: loss_count increments on each PLAY cycle with nloss_in=1 and saturates at 255. It holds through DONE/IDLE until the next run.

Reset
- REQ-029: reset forces state=IDLE, count=0, wptr=0, pc=0, obs=k=start=0, done=0, busy=0, loss_count=0. load_ready=1 in the cycle after reset.
- REQ-030: reset mid-PLAY aborts immediately. No done pulse is produced. RAM contents are not reset.

Configuration
- REQ-031: Macro STIM_PLAYER_LOSS_CNT_EN. When defined, the loss counter is built as in REQ-028.
- REQ-032: Without STIM_PLAYER_LOSS_CNT_EN, loss_count is tied to 0 and nloss_in is unused. All other behaviour is identical.

Structure
- REQ-033: Package stim_player_pkg holds: state enum; OPC_W=6; field constants OBS_BIT=5, K_HI=4, K_LO=1, START_BIT=0; LOSS_W=8.
- REQ-034: Sub-module stim_player_ram is a DEPTH x 6 register file with one synchronous write port and one asynchronous read port, no reset.

Verification
- REQ-035: Load 3 opcodes 6'b100011, 6'b000100, 6'b011111, then pulse run. Required: outputs after edges 1,2,3 are {1,0001,1}, {0,0010,0}, {0,1111,1}; done=1 in the cycle after the third edge; IDLE next.
- REQ-036: Load DEPTH opcodes. Required: load_ready=0 on the write after the 8th; a 9th load_valid is not stored; count stays 8.
- REQ-037: Apply pause for 2 cycles after opcode 1. Required: pc and outputs held 2 cycles; total playback = count+2 cycles.
- REQ-038: Drive nloss_in=1 for 300 PLAY cycles. Required: loss_count=255 with STIM_PLAYER_LOSS_CNT_EN defined, 0 without.
- REQ-039: Assert reset at pc=2 of a 5-opcode run. Required: all outputs 0 next cycle; no done; run afterwards is ignored until a reload because count=0.
- REQ-040: clear, run and load_valid in the same IDLE cycle. Required: count=0, state stays IDLE, nothing is written.
